// File: rtl/hblur3_stage.sv
// hblur3_stage: 3-tap [1 2 1]/4 horizontal smoothing of the raster-order pixel packet
// stream with edge replication, row-sequence checking and a registered output.
module hblur3_stage #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 320,
  parameter bit BYPASS = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] data_in,
  input  logic        valid_in,
  output logic [63:0] data_out,
  output logic        valid_out,
  output logic        frame_done,
  output logic        error
);

  localparam logic [8:0] LAST_X = 9'(WIDTH - 1);
  localparam logic [8:0] LAST_Y = 9'(HEIGHT - 1);

  logic [8:0]  in_x;
  logic [8:0]  in_y;
  logic [23:0] in_rgb;
  logic        unused_bits;

  assign in_x        = data_in[49:41];
  assign in_y        = data_in[40:32];
  assign in_rgb      = data_in[23:0];
  assign unused_bits = ^{data_in[63:50], data_in[31:24]};

  logic [23:0] p0;
  logic [23:0] p1;
  logic [8:0]  row_y;
  logic [8:0]  exp_x;
  logic        flush_pending;

  logic        start_row;
  logic        next_pix;
  logic        bad_pix;
  logic [23:0] pix_rgb;
  logic [23:0] flush_rgb;

  function automatic logic [7:0] tap3(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    logic [9:0] sum;
    sum = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c} + 10'd2;
    return sum[9:2];
  endfunction

  function automatic logic [23:0] blur(input logic [23:0] a, input logic [23:0] b,
                                       input logic [23:0] c);
    return {tap3(a[23:16], b[23:16], c[23:16]),
            tap3(a[15:8],  b[15:8],  c[15:8]),
            tap3(a[7:0],   b[7:0],   c[7:0])};
  endfunction

  function automatic logic [63:0] pack(input logic [8:0] x, input logic [8:0] y,
                                       input logic [23:0] rgb);
    return {14'b0, x, y, 8'b0, rgb};
  endfunction

  // Edge replication: the missing neighbour is replaced by the centre pixel,
  // which turns the interior formula into the 3b+c / a+3b edge forms.
  always_comb begin
    start_row = valid_in && (in_x == 9'd0);
    next_pix  = valid_in && (in_x != 9'd0) && (in_x == exp_x) && (in_x <= LAST_X);
    bad_pix   = valid_in && !start_row && !next_pix;
    pix_rgb   = blur((in_x == 9'd1) ? p1 : p0, p1, in_rgb);
    flush_rgb = blur(p0, p1, p1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0            <= '0;
      p1            <= '0;
      row_y         <= '0;
      exp_x         <= '0;
      flush_pending <= 1'b0;
      error         <= 1'b0;
    end else begin
      flush_pending <= next_pix && (in_x == LAST_X);
      if (start_row) begin
        if (exp_x != 9'd0) error <= 1'b1;
        p0    <= '0;
        p1    <= in_rgb;
        row_y <= in_y;
        exp_x <= 9'd1;
      end else if (next_pix) begin
        p0    <= p1;
        p1    <= in_rgb;
        exp_x <= (in_x == LAST_X) ? 9'd0 : in_x + 9'd1;
      end else if (bad_pix) begin
        error <= 1'b1;
        p0    <= '0;
        p1    <= '0;
        exp_x <= 9'd0;
      end
    end
  end

  // A flush can never coincide with an in-sequence pixel: after the last pixel
  // of a row only an x=0 strobe is accepted, and that emits nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (BYPASS) begin
        if (valid_in) begin
          data_out   <= pack(in_x, in_y, in_rgb);
          valid_out  <= 1'b1;
          frame_done <= (in_x == LAST_X) && (in_y == LAST_Y);
        end
      end else if (flush_pending) begin
        data_out   <= pack(LAST_X, row_y, flush_rgb);
        valid_out  <= 1'b1;
        frame_done <= (row_y == LAST_Y);
      end else if (next_pix) begin
        data_out  <= pack(in_x - 9'd1, row_y, pix_rgb);
        valid_out <= 1'b1;
      end
    end
  end

endmodule
